// File: rtl/score_controller.sv
// ---------------------------------------------------------------------------
// score_controller
//
// Game-level sequencer for the pong scoring path. Counts points from the ball
// logic's miss events, holds the ball at centre for a serve pause between
// rallies, detects game-over and restarts the match on a start press.
//
// Parameters:
//   WIN_SCORE     score at which a player wins (1..15)
//   PAUSE_CYCLES  clk cycles the ball is held before each serve (>= 1)
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   start      in   start button level (synchronised, debounced)
//   miss_p1    in   ball passed player 1's paddle -> point to player 2
//   miss_p2    in   ball passed player 2's paddle -> point to player 1
//   score_p1   out  player 1 score (4 bit, registered)
//   score_p2   out  player 2 score (4 bit, registered)
//   ball_en    out  ball may move (PLAY only)
//   ball_rst   out  hold ball at centre (IDLE, PAUSE, OVER)
//   serve_dir  out  0 = serve toward player 1, 1 = toward player 2
//   game_over  out  high in OVER only
// ---------------------------------------------------------------------------
module score_controller #(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned PAUSE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       miss_p1,
    input  logic       miss_p2,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       ball_en,
    output logic       ball_rst,
    output logic       serve_dir,
    output logic       game_over
);

    localparam int unsigned CntW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(PAUSE_CYCLES - 1);
    localparam logic [3:0] WinScore = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        StIdle,
        StPause,
        StPlay,
        StOver
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      score_p1_q, score_p1_d;
    logic [3:0]      score_p2_q, score_p2_d;
    logic            serve_q, serve_d;
    logic            start_q, miss1_q, miss2_q;

    logic            start_rise, miss1_rise, miss2_rise;
    logic [3:0]      p1_inc, p2_inc;

    // History is tracked in every state so a level already high on entry to
    // PLAY never produces a rising edge there.
    assign start_rise = start & ~start_q;
    assign miss1_rise = miss_p1 & ~miss1_q;
    assign miss2_rise = miss_p2 & ~miss2_q;

    assign p1_inc = score_p1_q + 4'd1;
    assign p2_inc = score_p2_q + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            score_p1_q <= 4'd0;
            score_p2_q <= 4'd0;
            serve_q    <= 1'b0;
            start_q    <= 1'b0;
            miss1_q    <= 1'b0;
            miss2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            score_p1_q <= score_p1_d;
            score_p2_q <= score_p2_d;
            serve_q    <= serve_d;
            start_q    <= start;
            miss1_q    <= miss_p1;
            miss2_q    <= miss_p2;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        serve_d    = serve_q;

        case (state_q)
            StIdle: begin
                score_p1_d = 4'd0;
                score_p2_d = 4'd0;
                if (start_rise) begin
                    state_d = StPause;
                    cnt_d   = CntLoad;
                    serve_d = 1'b0;
                end
            end

            StPause: begin
                // Exit on the cycle the counter reads zero: PAUSE_CYCLES cycles total.
                if (cnt_q == '0) begin
                    state_d = StPlay;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            StPlay: begin
                if (miss1_rise && miss2_rise) begin
                    // Simultaneous misses: replay the rally, nobody scores.
                    state_d = StPause;
                    cnt_d   = CntLoad;
                end else if (miss2_rise) begin
                    score_p1_d = p1_inc;
                    serve_d    = 1'b1;
                    if (p1_inc == WinScore) begin
                        state_d = StOver;
                    end else begin
                        state_d = StPause;
                        cnt_d   = CntLoad;
                    end
                end else if (miss1_rise) begin
                    score_p2_d = p2_inc;
                    serve_d    = 1'b0;
                    if (p2_inc == WinScore) begin
                        state_d = StOver;
                    end else begin
                        state_d = StPause;
                        cnt_d   = CntLoad;
                    end
                end
            end

            StOver: begin
                if (start_rise) begin
                    score_p1_d = 4'd0;
                    score_p2_d = 4'd0;
                    serve_d    = 1'b0;
                    state_d    = StPause;
                    cnt_d      = CntLoad;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign serve_dir = serve_q;
    assign ball_en   = (state_q == StPlay);
    assign ball_rst  = (state_q != StPlay);
    assign game_over = (state_q == StOver);

endmodule

// File: tb/tb_score_controller.sv
// ---------------------------------------------------------------------------
// tb_score_controller
//
// Directed bench for score_controller with PAUSE_CYCLES=4, WIN_SCORE=9.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_score_controller;

    localparam int unsigned Pause = 4;
    localparam int unsigned Win   = 9;

    logic       clk;
    logic       reset;
    logic       start;
    logic       miss_p1;
    logic       miss_p2;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       ball_en;
    logic       ball_rst;
    logic       serve_dir;
    logic       game_over;

    int tests;
    int fails;

    score_controller #(
        .WIN_SCORE    (Win),
        .PAUSE_CYCLES (Pause)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .miss_p1   (miss_p1),
        .miss_p2   (miss_p2),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .ball_en   (ball_en),
        .ball_rst  (ball_rst),
        .serve_dir (serve_dir),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs the observable outputs so one comparison covers all of them.
    function automatic logic [7:0] flags();
        return {4'b0, ball_en, ball_rst, serve_dir, game_over};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // One-cycle pulse on a miss line; returns at the first cycle after the edge.
    task automatic pulse_p1();
        miss_p1 = 1'b1;
        step();
        miss_p1 = 1'b0;
    endtask

    task automatic pulse_p2();
        miss_p2 = 1'b1;
        step();
        miss_p2 = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called on the first PAUSE cycle: expects Pause held cycles then PLAY.
    task automatic expect_pause(input string tag);
        for (int i = 0; i < Pause; i++) begin
            chk({tag, "_pause_en"}, {7'b0, ball_en}, 8'h00);
            chk({tag, "_pause_rst"}, {7'b0, ball_rst}, 8'h01);
            step();
        end
        chk({tag, "_play_en"}, {7'b0, ball_en}, 8'h01);
        chk({tag, "_play_rst"}, {7'b0, ball_rst}, 8'h00);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        start   = 1'b0;
        miss_p1 = 1'b0;
        miss_p2 = 1'b0;

        // Reset state: ball_en=0 ball_rst=1 serve_dir=0 game_over=0
        step();
        chk("rst_flags", flags(), 8'b0000_0100);
        chk("rst_s1", {4'b0, score_p1}, 8'd0);
        chk("rst_s2", {4'b0, score_p2}, 8'd0);
        reset = 1'b0;
        step();
        step();
        chk("idle_flags", flags(), 8'b0000_0100);

        // Start -> exactly Pause held cycles -> PLAY, 0/0, serve toward p1
        pulse_start();
        expect_pause("start");
        chk("start_s1", {4'b0, score_p1}, 8'd0);
        chk("start_s2", {4'b0, score_p2}, 8'd0);
        chk("start_dir", {7'b0, serve_dir}, 8'd0);

        // Start ignored while playing
        pulse_start();
        chk("play_start_ign", flags(), 8'b0000_1000);

        // miss_p2 -> point to p1, serve toward p2
        pulse_p2();
        chk("p2miss_s1", {4'b0, score_p1}, 8'd1);
        chk("p2miss_s2", {4'b0, score_p2}, 8'd0);
        chk("p2miss_dir", {7'b0, serve_dir}, 8'd1);
        expect_pause("p2miss");

        // miss_p1 held 10 cycles -> exactly one point to p2
        miss_p1 = 1'b1;
        step();
        chk("hold_first_s2", {4'b0, score_p2}, 8'd1);
        chk("hold_first_dir", {7'b0, serve_dir}, 8'd0);
        for (int i = 0; i < 9; i++) step();
        chk("hold_s2", {4'b0, score_p2}, 8'd1);
        chk("hold_s1", {4'b0, score_p1}, 8'd1);
        chk("hold_play", {7'b0, ball_en}, 8'd1);
        miss_p1 = 1'b0;
        step();

        // Point to p1 (2/1), then misses during PAUSE are ignored
        pulse_p2();
        chk("p1_two", {4'b0, score_p1}, 8'd2);
        miss_p1 = 1'b1;
        miss_p2 = 1'b1;
        step();
        miss_p1 = 1'b0;
        miss_p2 = 1'b0;
        step();
        step();
        step();
        chk("pausemiss_play", {7'b0, ball_en}, 8'd1);
        chk("pausemiss_s1", {4'b0, score_p1}, 8'd2);
        chk("pausemiss_s2", {4'b0, score_p2}, 8'd1);

        // Simultaneous misses -> replay, scores and serve_dir unchanged
        miss_p1 = 1'b1;
        miss_p2 = 1'b1;
        step();
        miss_p1 = 1'b0;
        miss_p2 = 1'b0;
        chk("both_s1", {4'b0, score_p1}, 8'd2);
        chk("both_s2", {4'b0, score_p2}, 8'd1);
        chk("both_dir", {7'b0, serve_dir}, 8'd1);
        expect_pause("both");

        // Drive p1 from 2 to 8
        for (int i = 0; i < 6; i++) begin
            pulse_p2();
            expect_pause("run");
        end
        chk("p1_eight", {4'b0, score_p1}, 8'd8);

        // Winning point: 9/1, OVER (ball_en=0 ball_rst=1 serve_dir=1 game_over=1)
        pulse_p2();
        chk("win_s1", {4'b0, score_p1}, 8'd9);
        chk("win_flags", flags(), 8'b0000_0111);
        step();
        pulse_p2();
        step();
        pulse_p1();
        step();
        chk("over_s1", {4'b0, score_p1}, 8'd9);
        chk("over_s2", {4'b0, score_p2}, 8'd1);
        chk("over_flags", flags(), 8'b0000_0111);

        // Restart from OVER
        pulse_start();
        chk("restart_s1", {4'b0, score_p1}, 8'd0);
        chk("restart_s2", {4'b0, score_p2}, 8'd0);
        chk("restart_flags", flags(), 8'b0000_0100);
        expect_pause("restart");

        // Build 3/5, ending in PAUSE
        for (int i = 0; i < 5; i++) begin
            pulse_p1();
            expect_pause("build");
        end
        for (int i = 0; i < 2; i++) begin
            pulse_p2();
            expect_pause("build");
        end
        pulse_p2();
        step();
        chk("pre_rst_s1", {4'b0, score_p1}, 8'd3);
        chk("pre_rst_s2", {4'b0, score_p2}, 8'd5);
        chk("pre_rst_flags", flags(), 8'b0000_0110);

        // Asynchronous reset away from any rising edge
        #2;
        reset = 1'b1;
        #1;
        chk("arst_s1", {4'b0, score_p1}, 8'd0);
        chk("arst_s2", {4'b0, score_p2}, 8'd0);
        chk("arst_flags", flags(), 8'b0000_0100);
        step();
        reset = 1'b0;
        for (int i = 0; i < Pause + 3; i++) step();
        chk("arst_idle", flags(), 8'b0000_0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/score_controller.md
Name: score_controller

Overview:
- Game-level sequencer for the pong scoring path.
- Counts points from the ball logic's miss events and gates the ball between rallies with a serve pause.
- Detects game-over and restarts the match on a start-button press.
- Drives the 4-bit per-player scores consumed by the multiplexed score display, plus ball-enable and ball-reset to the ball/paddle logic.

Parameters:
- WIN_SCORE, 9, score at which a player wins; must be 1..15.
- PAUSE_CYCLES, 1024, clk cycles the ball is held between a point or start and the next serve; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  start button level, already synchronised and debounced
- miss_p1  input  1  ball passed player 1's paddle (point to player 2); level, edge-detected internally
- miss_p2  input  1  ball passed player 2's paddle (point to player 1); level, edge-detected internally
- score_p1  output  4  player 1 score, registered
- score_p2  output  4  player 2 score, registered
- ball_en  output  1  ball may move; high only in PLAY
- ball_rst  output  1  hold ball at centre; high in IDLE, PAUSE, OVER
- serve_dir  output  1  serve direction: 0 = toward player 1, 1 = toward player 2; registered
- game_over  output  1  high only in OVER

Behaviour:
- Clocking and reset:
  - Clock clk; reset reset is asynchronous, active-high.
  - Reset values: state=IDLE, score_p1=0, score_p2=0, serve_dir=0, pause counter=0, edge-detect history regs=0.
  - Reset outputs: ball_en=0, ball_rst=1, game_over=0.
  - Reset mid-operation returns to IDLE immediately regardless of state.
- Edge detection:
  - start_rise = start & ~start_q; likewise miss1_rise and miss2_rise. History regs update every cycle.
  - A held-high miss or start counts once.
  - A miss already high when PLAY is entered does not score: history is updated in every state.
- States IDLE, PAUSE, PLAY, OVER. Outputs are decoded from registered state.
- IDLE:
  - Scores held at 0.
  - start_rise -> PAUSE; counter loaded PAUSE_CYCLES-1; serve_dir=0.
- PAUSE:
  - Counter decrements each cycle.
  - When counter==0 -> PLAY next cycle, so PAUSE lasts exactly PAUSE_CYCLES cycles.
  - Miss and start edges are ignored.
- PLAY:
  - miss2_rise only -> score_p1+1; serve_dir=1 (ball served toward the player who lost the point).
  - miss1_rise only -> score_p2+1; serve_dir=0.
  - Both rises in the same cycle -> no score change, serve_dir unchanged, -> PAUSE (replay).
  - After a scoring event: if the new score == WIN_SCORE -> OVER, else -> PAUSE with counter reloaded PAUSE_CYCLES-1.
  - Scores update in the same edge as the state change: miss rise sampled at edge N -> new score and ball_en=0 visible after edge N.
  - start_rise ignored.
- OVER:
  - Scores frozen; the winner's score equals WIN_SCORE.
  - start_rise -> both scores cleared to 0, serve_dir=0, -> PAUSE with counter reloaded.
- Arithmetic:
  - Scores are 4-bit unsigned.
  - An increment never exceeds WIN_SCORE, since the state leaves PLAY on reaching it; no wrap possible.
- Counter width: $clog2(PAUSE_CYCLES) bits, minimum 1.

Test Plan:
- Reset, then start pulse (PAUSE_CYCLES=4) -> PAUSE; ball_rst=1 for exactly 4 cycles, then ball_en=1, scores 0/0, serve_dir=0.
- In PLAY, 1-cycle miss_p2 -> score_p1=1 next cycle; ball_en=0 for 4 cycles; serve_dir=1; back to PLAY.
- miss_p1 held high for 10 cycles in PLAY -> score_p2 increments once only. Any miss during PAUSE -> no change.
- miss_p1 and miss_p2 rise in the same cycle -> scores unchanged, PAUSE entered, serve_dir unchanged.
- Drive player 1 to 8, then a 9th point -> score_p1=9, game_over=1, ball_en=0. Further misses -> no change. start -> 0/0, PAUSE, then PLAY.
- Assert reset asynchronously mid-PAUSE at score 3/5 -> outputs return to reset values immediately, without waiting for a clk edge; state IDLE.
